// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth signed multiplier: one Booth digit per clock.
// The finished product is held under a valid/ready handshake until it is accepted.
module booth_r4_seq_mult #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  product,
    output logic                  busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high. The input side is ready only in IDLE. The output side
    // holds product and out_valid stable until out_ready is seen.

    localparam int DIGITS = DATA_WIDTH / 2;
    localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [OUT_WIDTH-1:0]  mcand;
    logic [DATA_WIDTH:0]   b_win;
    logic [OUT_WIDTH-1:0]  acc;
    logic [OUT_WIDTH-1:0]  pp;
    logic [OUT_WIDTH-1:0]  acc_next;
    logic [KW-1:0]         k;
    logic                  last_digit;

    assign last_digit = (k == KW'(DIGITS - 1));
    assign acc_next   = acc + pp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = CALC;
            CALC:    if (last_digit) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CALC) || (state_q == DONE);

    // mcand already carries the 2k shift, and b_win[2:0] is the current
    // triplet {b[2k+1], b[2k], b[2k-1]}, so decoding needs no variable index.
    always_comb begin
        pp = '0;
        case (b_win[2:0])
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            b_win   <= '0;
            acc     <= '0;
            k       <= '0;
            product <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= {{(OUT_WIDTH - DATA_WIDTH){a[DATA_WIDTH-1]}}, a};
                        b_win <= {b, 1'b0};
                        acc   <= '0;
                        k     <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    mcand <= mcand << 2;
                    b_win <= b_win >> 2;
                    k     <= k + KW'(1);
                    if (last_digit) begin
                        product <= acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed bench for booth_r4_seq_mult: reset, signed corners, backpressure,
// mid-operation reset and a short randomised regression against a*b.
module tb_booth_r4_seq_mult;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        product;
    logic               busy;

    int n_vec;
    int n_err;
    logic [31:0] exp_q[$];

    booth_r4_seq_mult #(
        .DATA_WIDTH(16),
        .OUT_WIDTH (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .busy     (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one operation from IDLE to handshake, stalling out_ready for
    // 'stall' cycles once the product is valid. Called at a negedge.
    task automatic run_op(input string tag, input logic signed [15:0] av,
                          input logic signed [15:0] bv, input logic [31:0] exp,
                          input int stall);
        int lat;
        logic [31:0] want;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        tick();
        exp_q.push_back(exp);
        lat = 0;
        while (!out_valid && lat < 20) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_calc_in_ready"}, 32'(in_ready), 32'd0);
            in_valid = 1'($urandom_range(0, 1));
            a        = 16'($urandom);
            b        = 16'($urandom);
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd8);
        if (!out_valid) begin
            $display("FAIL %s_timeout: got out_valid=0, expected 1", tag);
            n_err++;
            in_valid = 1'b0;
            return;
        end
        want = exp_q.pop_front();
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = 16'($urandom);
            b        = 16'($urandom);
            check({tag, "_hold_product"}, product, want);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        check({tag, "_product"}, product, want);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_post_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_hold"}, product, want);
    endtask

    initial begin
        logic signed [15:0] ra;
        logic signed [15:0] rb;
        logic signed [31:0] rp;
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        check("rst_product", product, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("idle_stays", 32'(busy), 32'd0);

        run_op("a3_b5", 16'sd3, 16'sd5, 32'h0000_000F, 0);
        run_op("min_min", -16'sd32768, -16'sd32768, 32'h4000_0000, 1);
        run_op("min_max", -16'sd32768, 16'sd32767, 32'hC000_8000, 0);
        run_op("m1_p1", -16'sd1, 16'sd1, 32'hFFFF_FFFF, 2);
        run_op("zero_m7", 16'sd0, -16'sd7, 32'h0000_0000, 0);
        run_op("max_max", 16'sd32767, 16'sd32767, 32'h3FFF_0001, 0);
        run_op("m7_p9", -16'sd7, 16'sd9, 32'hFFFF_FFC1, 1);
        run_op("big_m2", 16'sd12345, -16'sd2, 32'hFFFF_9F8E, 0);
        run_op("backpressure", 16'sd100, -16'sd3, 32'hFFFF_FED4, 5);

        // reset on the 4th CALC cycle drops the operation
        a        = 16'sd1234;
        b        = 16'sd567;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_product", product, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mid_rst_no_emit", 32'(out_valid), 32'd0);
        end
        run_op("after_rst", 16'sd2, 16'sd2, 32'h0000_0004, 0);

        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rp = ra * rb;
            run_op("rand", ra, rb, rp, $urandom_range(0, 3));
        end

        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
